// File: rtl/arb_pkg.sv
// arb_pkg: state encoding, default widths and counter sizing shared by the memory port arbiter
package arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } arb_state_t;

    function automatic int cnt_w(input int max);
        return (max < 1) ? 1 : $clog2(max + 1);
    endfunction

endpackage

// File: rtl/arb_starve_counter.sv
// arb_starve_counter: saturating count of data grants taken while a fetch is waiting
module arb_starve_counter
    import arb_pkg::*;
#(
    parameter int MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam int            CW   = cnt_w(MAX);
    localparam logic [CW-1:0] CMAX = CW'(MAX);

    logic [CW-1:0] cnt;

    assign sat = (cnt == CMAX);

    // clear wins over increment; the count sticks at MAX until fetch is served
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !sat)
            cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between instruction fetch and data access
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W      = arb_pkg::ADDR_W,
    parameter int DATA_W      = arb_pkg::DATA_W,
    parameter int MAX_D_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    output logic              stall_if,
    output logic              stall_mem
);

    arb_state_t state;
    arb_state_t nxt;
    logic       arb_ok;
    logic       go_i;
    logic       go_d;
    logic       fin;
    logic       sat;
    logic       cnt_inc;
    logic       cnt_clr;

    assign stall_if  = i_req & ~i_done;
    assign stall_mem = d_req & ~d_done;

    // the cycle carrying a done pulse is a forced gap so a finishing requester is not re-granted
    assign arb_ok = !i_done && !d_done;

    // state register; reset abandons any grant in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    // next state: data first unless fetch has already waited through a full burst
    always_comb begin
        nxt = state;
        if (state == IDLE)
            nxt = !arb_ok                     ? IDLE  :
                  (d_req && (!i_req || !sat)) ? GNT_D :
                  i_req                       ? GNT_I : IDLE;
        else if (mem_done)
            nxt = IDLE;
    end

    // grant and completion strobes plus starvation counter controls
    always_comb begin
        go_i    = (state == IDLE) && (nxt == GNT_I);
        go_d    = (state == IDLE) && (nxt == GNT_D);
        fin     = (state != IDLE) && mem_done;
        cnt_inc = go_d && i_req;
        cnt_clr = go_i || ((state == IDLE) && !i_req);
    end

    arb_starve_counter #(
        .MAX (MAX_D_BURST)
    ) u_starve (
        .clk (clk),
        .rst (rst),
        .inc (cnt_inc),
        .clr (cnt_clr),
        .sat (sat)
    );

    // memory request is captured once at grant and held; read data is returned with the done pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            i_done <= fin && (state == GNT_I);
            d_done <= fin && (state == GNT_D);
            if (go_d) begin
                mem_req   <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
            end else if (go_i) begin
                mem_req  <= 1'b1;
                mem_we   <= 1'b0;
                mem_addr <= i_addr;
            end else if (fin) begin
                mem_req <= 1'b0;
            end
            if (fin && (state == GNT_I))
                i_rdata <= mem_rdata;
            if (fin && (state == GNT_D))
                d_rdata <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed table, corner sequences and random traffic against a memory/arbitration model
module tb_mem_port_arbiter;

    localparam int MB = 4;

    typedef struct {
        bit          iv;
        bit          dv;
        bit          we;
        logic [31:0] ia;
        logic [31:0] iw;
        logic [31:0] da;
        logic [31:0] dw;
        int          lat;
        int          cyc;
        int          first;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_done;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        stall_if;
    logic        stall_mem;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W      (32),
        .DATA_W      (32),
        .MAX_D_BURST (MB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_rdata   (i_rdata),
        .i_done    (i_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_done  (mem_done),
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem_m [logic [31:0]];
    int          lat = 2;
    int          cur_lat = 2;
    int          age = 0;
    bit          rand_lat = 0;
    bit          spur = 0;
    int          gnt = 0;
    int          waited = 0;
    int          gq[$];
    bit          g_we;
    logic [31:0] g_addr;
    logic [31:0] g_wdata;
    logic [31:0] last_i;
    logic [31:0] last_d;
    int          n_i = 0;
    int          n_d = 0;
    int          req_cycles = 0;
    vec_t        vt[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rd(input logic [31:0] a);
        return mem_m.exists(a) ? mem_m[a] : ((a ^ 32'h5A5A0000) + 32'd7);
    endfunction

    // one clock: score the DUT against the model, then play the memory for the coming cycle
    task automatic tick();
        bit          cpi, cpd, crq, cdone, ei, ed, want_d, dwe;
        logic [31:0] ia, da, dw, edata;
        cpi   = i_req;
        cpd   = d_req;
        crq   = mem_req;
        cdone = i_done | d_done;
        ia    = i_addr;
        da    = d_addr;
        dw    = d_wdata;
        dwe   = d_we;
        ei    = crq && mem_done && (gnt == 1);
        ed    = crq && mem_done && (gnt == 2);
        edata = mem_rdata;
        @(posedge clk);
        #1;
        if (!rst) begin
            gnt      = 0;
            age      = 0;
            waited   = 0;
            mem_done = 1'b0;
        end else begin
            chk("stall_if", stall_if, i_req & ~i_done);
            chk("stall_mem", stall_mem, d_req & ~d_done);
            chk("i_done", i_done, ei);
            chk("d_done", d_done, ed);
            if (i_done && ei) begin
                chk("i_rdata", i_rdata, edata);
                last_i = i_rdata;
                n_i++;
                i_req = 1'b0;
            end
            if (d_done && ed) begin
                chk("d_rdata", d_rdata, edata);
                last_d = d_rdata;
                n_d++;
                d_req = 1'b0;
            end
            if (ei || ed)
                gnt = 0;
            if (!crq) begin
                if (!cpi)
                    waited = 0;
                if (!cdone && (cpi || cpd)) begin
                    want_d  = cpd && (!cpi || waited < MB);
                    gnt     = want_d ? 2 : 1;
                    gq.push_back(gnt);
                    waited  = want_d ? waited + int'(cpi) : 0;
                    g_we    = want_d & dwe;
                    g_addr  = want_d ? da : ia;
                    g_wdata = dw;
                end
            end
            chk("mem_req", mem_req, gnt != 0);
            if (gnt != 0) begin
                req_cycles++;
                chk("mem_we", mem_we, g_we);
                chk("mem_addr", mem_addr, g_addr);
                if (gnt == 2)
                    chk("mem_wdata", mem_wdata, g_wdata);
            end
            if (mem_req) begin
                if (age == 0)
                    cur_lat = rand_lat ? int'($urandom_range(1, 4)) : lat;
                mem_done  = (age == cur_lat);
                mem_rdata = mem_done ? rd(mem_addr) : $urandom;
                if (mem_done && mem_we)
                    mem_m[mem_addr] = mem_wdata;
                age++;
            end else begin
                age       = 0;
                mem_done  = spur;
                mem_rdata = $urandom;
            end
        end
    endtask

    task automatic drain(input int max);
        int t = 0;
        while ((i_req || d_req || mem_req) && t < max) begin
            tick();
            t++;
        end
        checks++;
        if (i_req || d_req || mem_req) begin
            errors++;
            $display("FAIL drain: requests still open after %0d cycles, required none open", max);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   t;
        int   exp_s[6];
        vec_t v;
        rst       = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_done  = 1'b0;
        vt[0] = '{1'b1, 1'b0, 1'b0, 32'h100, 32'h00500093, 32'h0,    32'h0,        2, 3, 1};
        vt[1] = '{1'b1, 1'b1, 1'b1, 32'h104, 32'h00A00113, 32'h2000, 32'hDEADBEEF, 2, 6, 2};
        vt[2] = '{1'b0, 1'b1, 1'b0, 32'h0,   32'h0,        32'h3000, 32'h12345678, 3, 4, 2};
        vt[3] = '{1'b1, 1'b1, 1'b0, 32'h108, 32'h00000013, 32'h3004, 32'hCAFEF00D, 1, 4, 2};
        exp_s = '{2, 2, 2, 2, 1, 2};

        repeat (3) tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_i_done", i_done, 0);
        chk("rst_d_done", d_done, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        rst = 1'b1;
        tick();

        for (int k = 0; k < 4; k++) begin
            v = vt[k];
            if (v.iv)
                mem_m[v.ia] = v.iw;
            if (v.dv && !v.we)
                mem_m[v.da] = v.dw;
            lat        = v.lat;
            n_i        = 0;
            n_d        = 0;
            req_cycles = 0;
            gq.delete();
            i_req   = v.iv;
            i_addr  = v.ia;
            d_req   = v.dv;
            d_we    = v.we;
            d_addr  = v.da;
            d_wdata = v.dw;
            drain(80);
            chk($sformatf("v%0d_first", k), (gq.size() > 0) ? gq[0] : 0, v.first);
            chk($sformatf("v%0d_req_cycles", k), req_cycles, v.cyc);
            chk($sformatf("v%0d_dones", k), n_i + n_d, int'(v.iv) + int'(v.dv));
            if (v.iv)
                chk($sformatf("v%0d_i_rdata", k), last_i, v.iw);
            if (v.dv && !v.we)
                chk($sformatf("v%0d_d_rdata", k), last_d, v.dw);
            if (v.dv && v.we)
                chk($sformatf("v%0d_store", k), rd(v.da), v.dw);
            tick();
        end

        lat = 1;
        gq.delete();
        for (int c = 0; c < 200 && gq.size() < 6; c++) begin
            if (!i_req) begin
                i_req  = 1'b1;
                i_addr = 32'h400;
            end
            if (!d_req) begin
                d_req  = 1'b1;
                d_we   = 1'b0;
                d_addr = 32'h800 + 32'(c * 4);
            end
            tick();
        end
        drain(80);
        for (int s = 0; s < 6; s++)
            chk($sformatf("starve_grant%0d", s), (gq.size() > s) ? gq[s] : 0, exp_s[s]);

        n_i  = 0;
        n_d  = 0;
        gq.delete();
        spur = 1'b1;
        repeat (4) tick();
        spur = 1'b0;
        tick();
        chk("spur_grants", gq.size(), 0);
        chk("spur_dones", n_i + n_d, 0);
        chk("spur_mem_req", mem_req, 0);

        lat     = 6;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h5000;
        d_wdata = 32'h11112222;
        t = 0;
        while (!mem_req && t < 10) begin
            tick();
            t++;
        end
        tick();
        chk("rst_mid_pre_req", mem_req, 1);
        rst = 1'b0;
        #1;
        chk("rst_mid_async_req", mem_req, 0);
        chk("rst_mid_async_addr", mem_addr, 0);
        d_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        n_i = 0;
        n_d = 0;
        repeat (6) tick();
        chk("rst_mid_no_done", n_i + n_d, 0);
        chk("rst_mid_no_write", mem_m.exists(32'h5000), 0);

        rand_lat = 1'b1;
        n_i      = 0;
        n_d      = 0;
        gq.delete();
        for (int c = 0; c < 3000; c++) begin
            if (!i_req && $urandom_range(0, 2) == 0) begin
                i_req  = 1'b1;
                i_addr = 32'($urandom_range(0, 15)) << 2;
            end
            if (!d_req && $urandom_range(0, 3) != 0) begin
                d_req   = 1'b1;
                d_we    = 1'($urandom_range(0, 1));
                d_addr  = 32'($urandom_range(0, 15)) << 2;
                d_wdata = $urandom;
            end
            tick();
        end
        drain(100);
        chk("rand_grants_vs_dones", gq.size(), n_i + n_d);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one unified single-ported memory between instruction fetch (IF) and the data-memory stage (MEM) of the 5-stage pipeline.
- Grants one requester at a time and holds the memory request until the memory signals done.
- Routes the read data back to the granted requester and generates the IF and MEM stall signals for the hazard logic.
- Data has priority; a starvation counter guarantees fetch progress.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_D_BURST, 4, consecutive data grants allowed while a fetch is waiting; the next grant must go to fetch.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- i_req  in  1  fetch request; held high until i_done.
- i_addr  in  ADDR_W  fetch address.
- i_rdata  out  DATA_W  fetched instruction; valid only while i_done=1.
- i_done  out  1  one-cycle pulse: fetch complete.
- d_req  in  1  load/store request; held high until d_done.
- d_we  in  1  1=store, 0=load.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data; valid only while d_done=1.
- d_done  out  1  one-cycle pulse: data access complete.
- mem_req  out  1  request to memory.
- mem_we  out  1  write enable to memory.
- mem_addr  out  ADDR_W  address to memory.
- mem_wdata  out  DATA_W  write data to memory.
- mem_rdata  in  DATA_W  memory read data.
- mem_done  in  1  memory completion pulse, 1 or more cycles after mem_req rises.
- stall_if  out  1  = i_req & ~i_done.
- stall_mem  out  1  = d_req & ~d_done.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, burst counter=0. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, i_done, d_done, i_rdata, d_rdata.
- FSM states: IDLE, GNT_I, GNT_D.
- IDLE transitions:
  - d_req=1 and (i_req=0 or counter<MAX_D_BURST) -> GNT_D.
  - Otherwise i_req=1 -> GNT_I.
  - Otherwise stay in IDLE.
- Entering a grant state: mem_req, mem_we, mem_addr and mem_wdata are registered from the granted requester on the transition edge. They are held stable for the whole grant; requester inputs are not re-sampled. For a fetch grant, mem_we=0.
- In GNT_x, when mem_done=1:
  - Next cycle: x_done=1 for exactly one cycle; x_rdata = mem_rdata captured on the mem_done edge; mem_req=0.
  - Next state is IDLE.
- Minimum spacing between grants: one IDLE cycle (no back-to-back mem_req).
- Latency: request to done = 1 (grant) + memory latency + 1 (done) cycles.
- Counter rules:
  - Increments on each entry to GNT_D while i_req=1, saturating at MAX_D_BURST.
  - Resets to 0 on entry to GNT_I, or whenever i_req=0 in IDLE.
- Simultaneous i_req and d_req with counter<MAX_D_BURST: data wins.
- Simultaneous i_req and d_req with counter=MAX_D_BURST: fetch wins.
- Requester deasserting x_req mid-grant is illegal. The arbiter still completes the memory access; the x_done pulse is issued regardless.
- mem_done while in IDLE is ignored.
- stall_if and stall_mem are combinational from x_req and the registered x_done.
- Reset asserted mid-grant: immediate return to IDLE. mem_req drops asynchronously and no done pulse is issued.

Decomposition:
- Shared package arb_pkg holds:
  - State encoding: IDLE=2'd0, GNT_I=2'd1, GNT_D=2'd2.
  - Default widths ADDR_W and DATA_W.
- Optional sub-module: arb_starve_counter, the saturating counter with inc/clr inputs and a sat output.
- Everything else lives in one module.

Test Plan:
- Reset: drive rst=0 mid-grant with mem_req=1 -> mem_req=0 immediately, state IDLE; after release, no i_done or d_done pulse appears.
- Fetch only: i_req=1, i_addr=0x100, memory done after 2 cycles with 0x00500093 -> mem_req high for 3 cycles, mem_we=0, mem_addr=0x100, then i_done=1 for one cycle with i_rdata=0x00500093; stall_if=1 until that cycle.
- Store priority: i_req and d_req rise together, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF -> data granted first with mem_we=1, mem_wdata=0xDEADBEEF; fetch granted after one IDLE cycle following d_done.
- Starvation: i_req held with d_req re-raised after every d_done -> exactly 4 data grants, then 1 fetch grant, then counter=0 and data wins again.
- Load read-back: d_we=0, mem_rdata=0x12345678 at mem_done -> d_done pulse with d_rdata=0x12345678; mem_req low the same cycle.
- Spurious mem_done in IDLE -> no state change, no done pulses.
